// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RV32 loads/stores into single word accesses on a
// word-addressed memory, runs the ren/wen/ready handshake, aligns load data and flags faults.
module load_store_unit #(
    parameter int MEM_WORDS  = 1024,
    parameter int WADDR_BITS = 30,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [2:0]            cpu_funct3_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [31:0]           cpu_wdata_i,
    output logic [31:0]           cpu_rdata_o,
    output logic                  cpu_done_o,
    output logic                  cpu_stall_o,
    output logic                  cpu_err_o,
    output logic [1:0]            cpu_err_cause_o,
    output logic [WADDR_BITS-1:0] mem_addr_o,
    output logic                  mem_ren_o,
    output logic                  mem_wen_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_byte_sel_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_ready_i
);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [WADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_ren_q, mem_ren_d;
    logic                  mem_wen_q, mem_wen_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [3:0]            byte_sel_q, byte_sel_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [1:0]            cause_q, cause_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            lane_q, lane_d;

    logic                  illegal_size, misaligned, out_of_range;
    logic [3:0]            req_sel;
    logic [31:0]           req_wdata;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_data;

    // Request decode; funct3[1:0] encodes the access size for every legal code.
    always_comb begin
        if (cpu_we_i) begin
            illegal_size = cpu_funct3_i > 3'b010;
        end else begin
            illegal_size = (cpu_funct3_i == 3'b011) || (cpu_funct3_i[2:1] == 2'b11);
        end
        misaligned = ((cpu_funct3_i[1:0] == 2'b01) && cpu_addr_i[0]) ||
                     ((cpu_funct3_i[1:0] == 2'b10) && (cpu_addr_i[1:0] != 2'b00));
        out_of_range = {2'b00, cpu_addr_i[31:2]} >= 32'(MEM_WORDS);
        case (cpu_funct3_i[1:0])
            2'b00: begin
                req_sel   = 4'b0001 << cpu_addr_i[1:0];
                req_wdata = {4{cpu_wdata_i[7:0]}};
            end
            2'b01: begin
                req_sel   = cpu_addr_i[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{cpu_wdata_i[15:0]}};
            end
            default: begin
                req_sel   = 4'b1111;
                req_wdata = cpu_wdata_i;
            end
        endcase
    end

    // Load alignment uses the lane and size captured at request time, not the live CPU inputs.
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = mem_rdata_i[7:0];
            2'd1:    ld_byte = mem_rdata_i[15:8];
            2'd2:    ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase
        ld_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_ren_d   = mem_ren_q;
        mem_wen_d   = mem_wen_q;
        mem_wdata_d = mem_wdata_q;
        byte_sel_d  = byte_sel_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cause_d     = cause_q;
        timer_d     = timer_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    funct3_d = cpu_funct3_i;
                    lane_d   = cpu_addr_i[1:0];
                    if (illegal_size || misaligned || out_of_range) begin
                        err_d   = 1'b1;
                        cause_d = illegal_size ? 2'b00 : (misaligned ? 2'b01 : 2'b10);
                        state_d = S_DONE;
                    end else begin
                        mem_addr_d  = cpu_addr_i[WADDR_BITS+1:2];
                        byte_sel_d  = req_sel;
                        mem_wdata_d = req_wdata;
                        mem_ren_d   = ~cpu_we_i;
                        mem_wen_d   = cpu_we_i;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                mem_ren_d = 1'b0;
                mem_wen_d = 1'b0;
                timer_d   = '0;
                if (mem_wen_q) begin
                    err_d   = 1'b0;
                    cause_d = 2'b00;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ready_i) begin
                    rdata_d = ld_data;
                    err_d   = 1'b0;
                    cause_d = 2'b00;
                    state_d = S_DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    cause_d = 2'b11;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= '0;
            byte_sel_q  <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cause_q     <= 2'b00;
            timer_q     <= '0;
            funct3_q    <= '0;
            lane_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdata_q <= mem_wdata_d;
            byte_sel_q  <= byte_sel_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cause_q     <= cause_d;
            timer_q     <= timer_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
        end
    end

    assign cpu_done_o      = (state_q == S_DONE);
    assign cpu_stall_o     = cpu_req_i & ~cpu_done_o;
    assign cpu_rdata_o     = rdata_q;
    assign cpu_err_o       = err_q;
    assign cpu_err_cause_o = cause_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_ren_o       = mem_ren_q;
    assign mem_wen_o       = mem_wen_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign mem_byte_sel_o  = byte_sel_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and randomized accesses against a byte-level reference
// model, with a word memory model that supports variable read latency and never-ready reads.
module tb_load_store_unit;
    localparam int MEM_WORDS  = 1024;
    localparam int WADDR_BITS = 30;
    localparam int TIMEOUT    = 64;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  cpu_req = 1'b0;
    logic                  cpu_we = 1'b0;
    logic [2:0]            cpu_funct3 = '0;
    logic [31:0]           cpu_addr = '0;
    logic [31:0]           cpu_wdata = '0;
    logic [31:0]           cpu_rdata;
    logic                  cpu_done;
    logic                  cpu_stall;
    logic                  cpu_err;
    logic [1:0]            cpu_err_cause;
    logic [WADDR_BITS-1:0] mem_addr;
    logic                  mem_ren;
    logic                  mem_wen;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_byte_sel;
    logic [31:0]           mem_rdata = '0;
    logic                  mem_ready = 1'b1;

    always #5 clk = ~clk;

    load_store_unit #(
        .MEM_WORDS(MEM_WORDS), .WADDR_BITS(WADDR_BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_funct3_i(cpu_funct3),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_done_o(cpu_done), .cpu_stall_o(cpu_stall),
        .cpu_err_o(cpu_err), .cpu_err_cause_o(cpu_err_cause),
        .mem_addr_o(mem_addr), .mem_ren_o(mem_ren), .mem_wen_o(mem_wen),
        .mem_wdata_o(mem_wdata), .mem_byte_sel_o(mem_byte_sel),
        .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
    );

    int n_vec = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: no reset; ready drops on a read and returns rd_lat+1 cycles later (never if rd_hang).
    logic [31:0] mdl_mem [MEM_WORDS];
    bit          mem_init_done = 1'b0;
    int          rd_lat = 0;
    bit          rd_hang = 1'b0;
    bit          rd_pending = 1'b0;
    int          rd_cnt = 0;
    logic [31:0] rd_word = '0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < MEM_WORDS; i++) mdl_mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_byte_sel[b]) mdl_mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_ren) begin
            rd_word    <= mdl_mem[mem_addr[9:0]];
            rd_cnt     <= rd_lat;
            rd_pending <= !rd_hang;
            mem_ready  <= 1'b0;
        end else if (rd_pending) begin
            if (rd_cnt == 0) begin
                mem_ready  <= 1'b1;
                mem_rdata  <= rd_word;
                rd_pending <= 1'b0;
            end else begin
                rd_cnt <= rd_cnt - 1;
            end
        end
    end

    // Reference model: byte-granular view of the memory and the RV32 access rules.
    logic [31:0] ref_mem [MEM_WORDS];

    task automatic ref_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input bit hang,
                              output bit err, output logic [1:0] cause, output logic [3:0] sel,
                              output logic [31:0] wbus, output logic [31:0] rd);
        int nb, lane, widx;
        logic [31:0] v, mask;
        nb   = 1 << int'(f3[1:0]);
        lane = int'(a % 4);
        widx = int'(a[11:2]);
        err = 1'b0; cause = 2'b00; sel = '0; wbus = '0; rd = '0;
        if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) begin
            err = 1'b1; cause = 2'b00; return;
        end
        if (lane % nb != 0) begin
            err = 1'b1; cause = 2'b01; return;
        end
        if (a / 4 >= 32'(MEM_WORDS)) begin
            err = 1'b1; cause = 2'b10; return;
        end
        sel = 4'(((1 << nb) - 1) << lane);
        for (int i = 0; i < 4; i++) wbus[8*i +: 8] = wd[8*(i % nb) +: 8];
        if (we) begin
            for (int i = 0; i < 4; i++) if (sel[i]) ref_mem[widx][8*i +: 8] = wbus[8*i +: 8];
            return;
        end
        if (hang) begin
            err = 1'b1; cause = 2'b11; rd = '0; return;
        end
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
        v = (ref_mem[widx] >> (8*lane)) & mask;
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
        rd = v;
    endtask

    // One access: drive from a negedge, observe every following negedge until done.
    task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int lat, input bit hang);
        bit e_err;
        logic [1:0] e_cause;
        logic [3:0] e_sel;
        logic [31:0] e_wbus, e_rd;
        int exp_lat, n_ren, n_wen, strobe_cyc, k;
        bit both, stall_ok, seen_done, is_rd;
        logic [29:0] s_addr;
        logic [3:0] s_sel;
        logic [31:0] s_wdata;
        ref_access(we, f3, a, wd, hang, e_err, e_cause, e_sel, e_wbus, e_rd);
        if (e_err && e_cause == 2'b11) exp_lat = 2 + TIMEOUT;
        else if (e_err) exp_lat = 1;
        else if (we) exp_lat = 2;
        else exp_lat = 4 + lat;
        is_rd = !we && (!e_err || e_cause == 2'b11);

        @(negedge clk);
        check_eq("done_pulse_len", 32'(cpu_done), 32'd0);
        rd_lat = lat; rd_hang = hang;
        cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = wd;
        #1;
        stall_ok = cpu_stall;
        k = 0; seen_done = 0; both = 0; n_ren = 0; n_wen = 0; strobe_cyc = 0;
        s_addr = '0; s_sel = '0; s_wdata = '0;
        while (!seen_done && k < TIMEOUT + 20) begin
            @(negedge clk);
            k++;
            if (mem_ren && mem_wen) both = 1'b1;
            if (mem_ren || mem_wen) begin
                n_ren += int'(mem_ren); n_wen += int'(mem_wen);
                strobe_cyc = k; s_addr = mem_addr; s_sel = mem_byte_sel; s_wdata = mem_wdata;
            end
            if (cpu_done) seen_done = 1'b1;
            else begin
                if (!cpu_stall) stall_ok = 1'b0;
                if (k >= 2 && !we) begin
                    cpu_addr = $urandom; cpu_funct3 = 3'($urandom_range(0, 7));
                    cpu_wdata = $urandom; cpu_we = 1'($urandom_range(0, 1));
                end
            end
        end
        check_eq("done_seen", 32'(seen_done), 32'd1);
        if (!seen_done) begin
            cpu_req = 1'b0;
            return;
        end
        check_eq("latency", 32'(k), 32'(exp_lat));
        check_eq("stall_while_busy", 32'(stall_ok), 32'd1);
        check_eq("stall_at_done", 32'(cpu_stall), 32'd0);
        check_eq("err", 32'(cpu_err), 32'(e_err));
        if (e_err) check_eq("cause", 32'(cpu_err_cause), 32'(e_cause));
        check_eq("ren_count", 32'(n_ren), is_rd ? 32'd1 : 32'd0);
        check_eq("wen_count", 32'(n_wen), (we && !e_err) ? 32'd1 : 32'd0);
        check_eq("ren_wen_excl", 32'(both), 32'd0);
        if (n_ren + n_wen == 1) begin
            check_eq("strobe_cycle", 32'(strobe_cyc), 32'd1);
            check_eq("mem_addr", 32'(s_addr), 32'(a[31:2]));
            check_eq("byte_sel", 32'(s_sel), 32'(e_sel));
            if (we) check_eq("mem_wdata", s_wdata, e_wbus);
        end
        if (is_rd) check_eq("rdata", cpu_rdata, e_rd);
        $display("%s f3=%0d addr=%h wdata=%h lat=%0d hang=%0d -> rdata=%h err=%0d cause=%0d cycles=%0d",
                 we ? "ST" : "LD", f3, a, wd, lat, hang, cpu_rdata, cpu_err, cpu_err_cause, k);
        cpu_req = 1'b0;
    endtask

    initial begin
        bit we, hang, bad;
        logic [2:0] f3;
        logic [31:0] a;
        int r;

        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);

        repeat (3) @(negedge clk);
        check_eq("rst_mem_ren", 32'(mem_ren), 32'd0);
        check_eq("rst_mem_wen", 32'(mem_wen), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_byte_sel", 32'(mem_byte_sel), 32'd0);
        check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
        check_eq("rst_cpu_done", 32'(cpu_done), 32'd0);
        check_eq("rst_cpu_err", 32'(cpu_err), 32'd0);
        check_eq("rst_cause", 32'(cpu_err_cause), 32'd0);
        reset = 1'b0;

        do_access(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
        do_access(1'b1, 3'b000, 32'h13, 32'h0000_00A5, 0, 1'b0);
        do_access(1'b0, 3'b100, 32'h13, 32'h0, 2, 1'b0);
        check_eq("lbu_literal", cpu_rdata, 32'h0000_00A5);
        do_access(1'b0, 3'b000, 32'h13, 32'h0, 0, 1'b0);
        check_eq("lb_literal", cpu_rdata, 32'hFFFF_FFA5);
        do_access(1'b1, 3'b010, 32'h14, 32'h8001_7FFF, 0, 1'b0);
        do_access(1'b0, 3'b001, 32'h16, 32'h0, 6, 1'b0);
        check_eq("lh_literal", cpu_rdata, 32'hFFFF_8001);
        do_access(1'b0, 3'b010, 32'h2, 32'h0, 0, 1'b0);
        do_access(1'b0, 3'b010, 32'(4 * MEM_WORDS), 32'h0, 0, 1'b0);
        do_access(1'b0, 3'b011, 32'h0, 32'h0, 0, 1'b0);
        do_access(1'b1, 3'b011, 32'h4, 32'h1234_5678, 0, 1'b0);
        do_access(1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b1);
        check_eq("timeout_rdata", cpu_rdata, 32'd0);
        do_access(1'b0, 3'b010, 32'h14, 32'h0, TIMEOUT - 2, 1'b0);

        // Reset in ISSUE (k=1) and in WAIT (k=3): strobes and done drop at once, access is discarded.
        for (int rk = 1; rk <= 3; rk += 2) begin
            @(negedge clk);
            rd_lat = 5; rd_hang = 1'b0;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h20;
            @(negedge clk);
            check_eq("pre_reset_ren", 32'(mem_ren), 32'd1);
            repeat (rk - 1) @(negedge clk);
            reset = 1'b1;
            #1;
            check_eq("reset_ren", 32'(mem_ren), 32'd0);
            check_eq("reset_done", 32'(cpu_done), 32'd0);
            check_eq("reset_addr", 32'(mem_addr), 32'd0);
            cpu_req = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            bad = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (cpu_done || mem_ren || mem_wen) bad = 1'b1;
            end
            check_eq("post_reset_quiet", 32'(bad), 32'd0);
            do_access(1'b1, 3'b010, 32'h24, 32'hCAFE_0000 + 32'(rk), 0, 1'b0);
        end

        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 > 3'd2) f3 = f3 + 3'd1;
            end
            r = $urandom_range(0, 19);
            if (r == 0) a = $urandom;
            else if (r == 1) a = 32'h1000 + 32'($urandom_range(0, 15));
            else a = 32'($urandom_range(0, 63));
            hang = ($urandom_range(0, 11) == 0);
            do_access(we, f3, a, $urandom, $urandom_range(0, 8), hang);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got expired, expected completion");
        $fatal(1, "time limit");
    end
endmodule
